// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences the PLL reset, qualifies LOCK over a
// stability window, retries on timeout and releases the system reset.
module pll_lock_supervisor #(
  parameter int unsigned RESET_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65536,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 7,
  parameter int unsigned SYNC_STAGES   = 2,
  localparam int unsigned RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               lock_in,
  input  logic               retry_req,
  output logic               pll_reset,
  output logic               sys_rst_n,
  output logic               locked_ok,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [7:0]         lock_loss_cnt
);

  localparam int unsigned MAX_RS  = (RESET_CYCLES > STABLE_CYCLES) ? RESET_CYCLES : STABLE_CYCLES;
  localparam int unsigned CNT_MAX = (LOCK_TIMEOUT > MAX_RS) ? LOCK_TIMEOUT : MAX_RS;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]   WAIT_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RST,
    S_WAIT,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t               state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [RETRY_W-1:0]   retry_d;
  logic [7:0]           loss_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 lock_s;
  logic                 pll_reset_d, sys_rst_n_d, locked_ok_d, fail_d;

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Bring the asynchronous PLL LOCK into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], lock_in};
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_RST;
      cnt           <= '0;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
      pll_reset     <= 1'b1;
      sys_rst_n     <= 1'b0;
      locked_ok     <= 1'b0;
      fail          <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      retry_cnt     <= retry_d;
      lock_loss_cnt <= loss_d;
      pll_reset     <= pll_reset_d;
      sys_rst_n     <= sys_rst_n_d;
      locked_ok     <= locked_ok_d;
      fail          <= fail_d;
    end
  end

  // Next-state and counter update; lock wins over timeout, a drop wins over completion
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    retry_d = retry_cnt;
    loss_d  = lock_loss_cnt;
    case (state)
      S_RST: begin
        if (cnt == RST_LAST) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (lock_s) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt == WAIT_LAST) begin
          cnt_d = '0;
          if (retry_cnt == RETRY_MAX) begin
            state_d = S_FAIL;
          end else begin
            state_d = S_RST;
            retry_d = retry_cnt + RETRY_W'(1);
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_d = S_RST;
          cnt_d   = '0;
          if (lock_loss_cnt != '1) loss_d = lock_loss_cnt + 8'd1;
        end
      end
      S_FAIL: begin
        if (retry_req) begin
          state_d = S_RST;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      default: begin
        state_d = S_RST;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decoded from the next state so they switch on the same edge as state
  always_comb begin
    pll_reset_d = (state_d == S_RST) || (state_d == S_FAIL);
    sys_rst_n_d = (state_d == S_RUN);
    locked_ok_d = (state_d == S_RUN);
    fail_d      = (state_d == S_FAIL);
  end

endmodule
